// File: rtl/servo_pwm_driver.sv
// Servo actuator: captures signed PID results on ready rising edges, scales and clamps them
// around a centre width, and drives a double-buffered, frame-synchronous servo PWM.
module servo_pwm_driver #(
    parameter int unsigned FRAME_CYCLES  = 1_000_000,
    parameter int unsigned CENTER_CYCLES = 75_000,
    parameter int unsigned MIN_CYCLES    = 50_000,
    parameter int unsigned MAX_CYCLES    = 100_000,
    parameter int unsigned GAIN_SHIFT    = 2,
    parameter int unsigned CNT_W         = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      data,
    input  logic             ready,
    input  logic             enable,
    output logic             pwm,
    output logic             frame_start,
    output logic [CNT_W-1:0] pulse_width,
    output logic             clamped,
    output logic             overrun
);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CENTER_W = CNT_W'(CENTER_CYCLES);
    localparam logic [CNT_W-1:0]  MIN_W    = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0]  MAX_W    = CNT_W'(MAX_CYCLES);
    localparam logic signed [31:0] CENTER_S = $signed(32'(CENTER_CYCLES));
    localparam logic signed [31:0] MIN_S    = $signed(32'(MIN_CYCLES));
    localparam logic signed [31:0] MAX_S    = $signed(32'(MAX_CYCLES));

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             en_frame_q, en_frame_d;
    logic             ready_d_q, ready_d_d;
    logic             got_cap_q, got_cap_d;
    logic             pwm_q, pwm_d;
    logic             frame_start_q, frame_start_d;
    logic             clamped_q, clamped_d;
    logic             overrun_q, overrun_d;

    logic                cap;
    logic                wrap;
    logic signed [31:0]  data_s;
    logic signed [31:0]  sum_s;
    logic [CNT_W-1:0]    target;
    logic                limited;

    // Scaled command around centre, clamped to the safe window
    always_comb begin
        data_s  = {{16{data[15]}}, data};
        sum_s   = CENTER_S + (data_s <<< GAIN_SHIFT);
        target  = CNT_W'(sum_s);
        limited = 1'b0;
        if (sum_s < MIN_S) begin
            target  = MIN_W;
            limited = 1'b1;
        end else if (sum_s > MAX_S) begin
            target  = MAX_W;
            limited = 1'b1;
        end
    end

    // Next-state: capture into the shadow width, promote it at the frame wrap
    always_comb begin
        cap           = ready & ~ready_d_q;
        wrap          = (count_q == LAST_CNT);
        count_d       = wrap ? '0 : count_q + CNT_W'(1);
        ready_d_d     = ready;
        pending_d     = cap ? target : pending_q;
        clamped_d     = cap ? limited : clamped_q;
        active_d      = active_q;
        en_frame_d    = en_frame_q;
        got_cap_d     = got_cap_q | cap;
        overrun_d     = overrun_q | (cap & got_cap_q);
        pwm_d         = en_frame_q & (count_q < active_q);
        frame_start_d = (count_q == '0);
        if (wrap) begin
            active_d   = pending_d;
            en_frame_d = enable;
            got_cap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            pending_q     <= CENTER_W;
            active_q      <= CENTER_W;
            en_frame_q    <= 1'b0;
            ready_d_q     <= 1'b0;
            got_cap_q     <= 1'b0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
            clamped_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            count_q       <= count_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            en_frame_q    <= en_frame_d;
            ready_d_q     <= ready_d_d;
            got_cap_q     <= got_cap_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            clamped_q     <= clamped_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pwm         = pwm_q;
    assign frame_start = frame_start_q;
    assign pulse_width = active_q;
    assign clamped     = clamped_q;
    assign overrun     = overrun_q;

endmodule
